// File: rtl/seq_hybrid_adder.sv
// Multi-cycle adder/subtractor: adds one BLOCK-bit slice per cycle with
// carry-lookahead inside the slice and a registered carry between slices.
module seq_hybrid_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NBLK  = WIDTH / BLOCK;
    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IDX_W-1:0] blk_idx;
    logic             accept;
    logic             last_blk;

    logic [BLOCK-1:0] gen;
    logic [BLOCK-1:0] prop;
    logic [BLOCK:0]   blk_c;
    logic [BLOCK-1:0] blk_sum;
    logic             g_acc;
    logic             p_acc;
    logic [WIDTH-1:0] s_nxt;

    assign accept   = (state == IDLE) && start;
    assign last_blk = (blk_idx == LAST_IDX);
    assign ready    = (state == IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_blk) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Group generate/propagate prefix: each carry is expressed directly from
    // the slice carry-in rather than rippled through the previous sum bit.
    always_comb begin
        // NOTE: blocking assignments here are intentional; g_acc/p_acc are
        // combinational accumulators evaluated in loop order.
        gen      = a_reg[int'(blk_idx)*BLOCK +: BLOCK] & b_reg[int'(blk_idx)*BLOCK +: BLOCK];
        prop     = a_reg[int'(blk_idx)*BLOCK +: BLOCK] ^ b_reg[int'(blk_idx)*BLOCK +: BLOCK];
        g_acc    = 1'b0;
        p_acc    = 1'b1;
        blk_c    = '0;
        blk_c[0] = carry;
        for (int i = 0; i < BLOCK; i++) begin
            g_acc      = gen[i] | (prop[i] & g_acc);
            p_acc      = prop[i] & p_acc;
            blk_c[i+1] = g_acc | (p_acc & carry);
        end
        blk_sum = prop ^ blk_c[BLOCK-1:0];
        s_nxt   = S;
        s_nxt[int'(blk_idx)*BLOCK +: BLOCK] = blk_sum;
    end

    // Flags are cleared on acceptance and only set on the final slice, so
    // they read 0 throughout RUN and hold until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            S       <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            blk_idx <= '0;
        end else if (accept) begin
            carry   <= sub ? ~c_in : c_in;
            blk_idx <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (state == RUN) begin
            S     <= s_nxt;
            carry <= blk_c[BLOCK];
            if (last_blk) begin
                c_out <= blk_c[BLOCK];
                ovf   <= blk_c[BLOCK] ^ blk_c[BLOCK-1];
                zero  <= (s_nxt == '0);
            end else begin
                blk_idx <= blk_idx + 1'b1;
            end
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on
    // acceptance before being read, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
        end
    end

endmodule

// File: tb/tb_seq_hybrid_adder.sv
// Directed and random checks of seq_hybrid_adder with BLOCK = 8, 32 and 4
// sharing one stimulus bus; each instance is checked against its own latency.
module tb_seq_hybrid_adder;

    localparam int W  = 32;
    localparam int NI = 3;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sub;
    logic          c_in;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [NI-1:0] ready_v;
    logic [NI-1:0] done_v;
    logic [NI-1:0] cout_v;
    logic [NI-1:0] ovf_v;
    logic [NI-1:0] zero_v;
    logic [W-1:0]  s_v [NI];

    int            checks = 0;
    int            errors = 0;
    int            n_done   [NI];
    int            lat      [NI];
    int            run_bad  [NI];
    int            hold_bad [NI];
    logic [W-1:0]  r_s [NI];
    logic [NI-1:0] r_c;
    logic [NI-1:0] r_v;
    logic [NI-1:0] r_z;

    always #5 clk = ~clk;

    seq_hybrid_adder #(.WIDTH(W), .BLOCK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .ready(ready_v[0]), .done(done_v[0]), .S(s_v[0]), .c_out(cout_v[0]),
        .ovf(ovf_v[0]), .zero(zero_v[0])
    );

    seq_hybrid_adder #(.WIDTH(W), .BLOCK(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .ready(ready_v[1]), .done(done_v[1]), .S(s_v[1]), .c_out(cout_v[1]),
        .ovf(ovf_v[1]), .zero(zero_v[1])
    );

    seq_hybrid_adder #(.WIDTH(W), .BLOCK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .ready(ready_v[2]), .done(done_v[2]), .S(s_v[2]), .c_out(cout_v[2]),
        .ovf(ovf_v[2]), .zero(zero_v[2])
    );

    // Cycle in which done is expected, counting the start edge's cycle as 0.
    function automatic int exp_lat(input int i);
        return (i == 0) ? 5 : (i == 1) ? 2 : 9;
    endfunction

    // Reference arithmetic: unsigned 33-bit for carry/borrow, signed 64-bit for overflow.
    function automatic vec_t model(input logic s, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic ci);
        vec_t        v;
        logic [W:0]  u;
        longint      r;
        v.sub = s;
        v.a   = x;
        v.b   = y;
        v.cin = ci;
        if (!s) begin
            u   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            v.c = u[W];
            r   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end else begin
            u   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
            v.c = ~u[W];
            r   = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
        end
        v.s = u[W-1:0];
        v.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        v.z = (u[W-1:0] == '0);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation, scrambles operands afterwards, optionally pulses a
    // second start in cycle 2, and records what each instance produced.
    task automatic run_op(input vec_t v, input bit inject);
        sub   = v.sub;
        a     = v.a;
        b     = v.b;
        c_in  = v.cin;
        start = 1'b1;
        for (int i = 0; i < NI; i++) begin
            n_done[i]   = 0;
            lat[i]      = 0;
            run_bad[i]  = 0;
            hold_bad[i] = 0;
            r_s[i]      = '0;
        end
        r_c = '0;
        r_v = '0;
        r_z = '0;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                if (done_v[i]) begin
                    n_done[i]++;
                    lat[i] = cyc;
                    r_s[i] = s_v[i];
                    r_c[i] = cout_v[i];
                    r_v[i] = ovf_v[i];
                    r_z[i] = zero_v[i];
                end else if (n_done[i] > 0) begin
                    if (ready_v[i] !== 1'b1 || s_v[i] !== r_s[i] || cout_v[i] !== r_c[i] ||
                        ovf_v[i] !== r_v[i] || zero_v[i] !== r_z[i])
                        hold_bad[i]++;
                end else if (ready_v[i] !== 1'b0 || cout_v[i] !== 1'b0 ||
                             ovf_v[i] !== 1'b0 || zero_v[i] !== 1'b0) begin
                    run_bad[i]++;
                end
            end
            a     = $urandom;
            b     = $urandom;
            sub   = 1'($urandom_range(1));
            c_in  = 1'($urandom_range(1));
            start = inject && (cyc == 2);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        sub   = 1'b0;
        a     = 32'd5;
        b     = 32'd6;
        c_in  = 1'b0;
        tick();
        tick();
        checks++;
        if (ready_v !== '1 || done_v !== '0) begin
            errors++;
            $display("FAIL reset ready/done: ready=%b done=%b, expected ready=111 done=000", ready_v, done_v);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (s_v[i] !== '0 || cout_v[i] !== 1'b0 || ovf_v[i] !== 1'b0 || zero_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset outputs inst%0d: S=%h c=%b v=%b z=%b, expected all 0",
                         i, s_v[i], cout_v[i], ovf_v[i], zero_v[i]);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_add();
        vec_t vecs [7];
        vecs = '{
            '{1'b0, 32'd14,         32'd11,         1'b0, 32'd25,         1'b0, 1'b0, 1'b0},
            '{1'b0, 32'd41,         32'hFFFF_FFE5,  1'b0, 32'd14,         1'b1, 1'b0, 1'b0},
            '{1'b0, 32'hFFFF_FFCF,  32'hFFFF_FFB3,  1'b0, 32'hFFFF_FF82,  1'b1, 1'b0, 1'b0},
            '{1'b0, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0},
            '{1'b0, 32'hFFFF_FFFF,  32'd0,          1'b1, 32'd0,          1'b1, 1'b0, 1'b1},
            '{1'b0, 32'd5,          32'd6,          1'b1, 32'd12,         1'b0, 1'b0, 1'b0},
            '{1'b0, 32'd0,          32'd0,          1'b0, 32'd0,          1'b0, 1'b0, 1'b1}
        };
        for (int k = 0; k < 7; k++) begin
            run_op(vecs[k], 1'b0);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (n_done[i] !== 1 || lat[i] !== exp_lat(i)) begin
                    errors++;
                    $display("FAIL add%0d inst%0d done: count=%0d cycle=%0d, expected count=1 cycle=%0d",
                             k, i, n_done[i], lat[i], exp_lat(i));
                end
                checks++;
                if (r_s[i] !== vecs[k].s || r_c[i] !== vecs[k].c || r_v[i] !== vecs[k].v || r_z[i] !== vecs[k].z) begin
                    errors++;
                    $display("FAIL add%0d inst%0d result: S=%h c=%b v=%b z=%b, expected S=%h c=%b v=%b z=%b",
                             k, i, r_s[i], r_c[i], r_v[i], r_z[i], vecs[k].s, vecs[k].c, vecs[k].v, vecs[k].z);
                end
                checks++;
                if (run_bad[i] != 0 || hold_bad[i] != 0) begin
                    errors++;
                    $display("FAIL add%0d inst%0d framing: run_bad=%0d hold_bad=%0d, expected 0 0",
                             k, i, run_bad[i], hold_bad[i]);
                end
            end
        end
    endtask

    task automatic test_sub();
        vec_t vecs [6];
        vecs = '{
            '{1'b1, 32'd12,         32'd11,  1'b0, 32'd1,          1'b1, 1'b0, 1'b0},
            '{1'b1, 32'd0,          32'd1,   1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0},
            '{1'b1, 32'h8000_0000,  32'd1,   1'b0, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0},
            '{1'b1, 32'd10,         32'd3,   1'b1, 32'd6,          1'b1, 1'b0, 1'b0},
            '{1'b1, 32'd7,          32'd7,   1'b0, 32'd0,          1'b1, 1'b0, 1'b1},
            '{1'b1, 32'd5,          32'd5,   1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0}
        };
        for (int k = 0; k < 6; k++) begin
            run_op(vecs[k], 1'b0);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (n_done[i] !== 1 || lat[i] !== exp_lat(i)) begin
                    errors++;
                    $display("FAIL sub%0d inst%0d done: count=%0d cycle=%0d, expected count=1 cycle=%0d",
                             k, i, n_done[i], lat[i], exp_lat(i));
                end
                checks++;
                if (r_s[i] !== vecs[k].s || r_c[i] !== vecs[k].c || r_v[i] !== vecs[k].v || r_z[i] !== vecs[k].z) begin
                    errors++;
                    $display("FAIL sub%0d inst%0d result: S=%h c=%b v=%b z=%b, expected S=%h c=%b v=%b z=%b",
                             k, i, r_s[i], r_c[i], r_v[i], r_z[i], vecs[k].s, vecs[k].c, vecs[k].v, vecs[k].z);
                end
                checks++;
                if (run_bad[i] != 0 || hold_bad[i] != 0) begin
                    errors++;
                    $display("FAIL sub%0d inst%0d framing: run_bad=%0d hold_bad=%0d, expected 0 0",
                             k, i, run_bad[i], hold_bad[i]);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        vec_t v;
        v = '{1'b0, 32'd100, 32'd23, 1'b0, 32'd123, 1'b0, 1'b0, 1'b0};
        run_op(v, 1'b1);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (n_done[i] !== 1 || lat[i] !== exp_lat(i)) begin
                errors++;
                $display("FAIL ignore inst%0d done: count=%0d cycle=%0d, expected count=1 cycle=%0d",
                         i, n_done[i], lat[i], exp_lat(i));
            end
            checks++;
            if (r_s[i] !== v.s || r_c[i] !== v.c || r_v[i] !== v.v || r_z[i] !== v.z) begin
                errors++;
                $display("FAIL ignore inst%0d result: S=%h c=%b v=%b z=%b, expected S=%h c=%b v=%b z=%b",
                         i, r_s[i], r_c[i], r_v[i], r_z[i], v.s, v.c, v.v, v.z);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        sub   = 1'b0;
        a     = 32'h0000_1234;
        b     = 32'h0000_1111;
        c_in  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ready_v !== '1 || done_v !== '0) begin
            errors++;
            $display("FAIL midreset ready/done: ready=%b done=%b, expected ready=111 done=000", ready_v, done_v);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (s_v[i] !== '0 || cout_v[i] !== 1'b0 || ovf_v[i] !== 1'b0 || zero_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL midreset outputs inst%0d: S=%h c=%b v=%b z=%b, expected all 0",
                         i, s_v[i], cout_v[i], ovf_v[i], zero_v[i]);
            end
        end
        seen = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (done_v !== '0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset stray done: cycles with done=%0d, expected 0", seen);
        end
    endtask

    task automatic test_random();
        vec_t v;
        for (int k = 0; k < 30; k++) begin
            v = model(1'($urandom_range(1)), $urandom, $urandom, 1'($urandom_range(1)));
            run_op(v, 1'b0);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (n_done[i] !== 1 || lat[i] !== exp_lat(i) || run_bad[i] != 0 || hold_bad[i] != 0) begin
                    errors++;
                    $display("FAIL rand%0d inst%0d framing: count=%0d cycle=%0d run_bad=%0d hold_bad=%0d, expected 1 %0d 0 0",
                             k, i, n_done[i], lat[i], run_bad[i], hold_bad[i], exp_lat(i));
                end
                checks++;
                if (r_s[i] !== v.s || r_c[i] !== v.c || r_v[i] !== v.v || r_z[i] !== v.z) begin
                    errors++;
                    $display("FAIL rand%0d inst%0d result: sub=%b a=%h b=%h cin=%b got S=%h c=%b v=%b z=%b, expected S=%h c=%b v=%b z=%b",
                             k, i, v.sub, v.a, v.b, v.cin, r_s[i], r_c[i], r_v[i], r_z[i], v.s, v.c, v.v, v.z);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
